// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 4-bit-opcode accumulator ISA.
// Optional retire counter output enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_control #(
   parameter int OPW         = 4,
   parameter int ALUW        = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNTW        = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OPW-1:0]  instr,
   input  logic            cond_true,
   input  logic            mem_ready,
   output logic            ir_load,
   output logic            pc_en,
   output logic            pc_branch,
   output logic [ALUW-1:0] alu_op,
   output logic            itype,
   output logic            movf,
   output logic            rd_mem,
   output logic            mem_req,
   output logic            mem_we,
   output logic            reg_write,
   output logic            busy,
   output logic            halted,
   output logic            mem_err,
   output logic            retire
`ifdef CTRL_RETIRE_CNT_EN
   ,
   output logic [CNTW-1:0] retire_count
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] C_SKIP = 3'd0;
   localparam logic [2:0] C_JMP  = 3'd1;
   localparam logic [2:0] C_CJMP = 3'd2;
   localparam logic [2:0] C_STR  = 3'd3;
   localparam logic [2:0] C_LD   = 3'd4;
   localparam logic [2:0] C_HALT = 3'd5;
   localparam logic [2:0] C_WB   = 3'd6;

   localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT - 1);

   logic [2:0]     state_q, state_d;
   logic [OPW-1:0] op_q;
   logic [WW-1:0]  wait_q, wait_d;
   logic           mem_err_q, mem_err_d;

   logic [3:0]     op_lo_s;
   logic           op_nop_s;
   logic [2:0]     cls_s;
   logic [2:0]     alu_s;
   logic           itype_s;
   logic           movf_s;

   assign op_lo_s  = op_q[3:0];
   assign op_nop_s = ((op_q >> 4) != {OPW{1'b0}});

   // Opcode classification and EXEC-stage ALU controls from the registered opcode
   always_comb begin
      cls_s   = C_SKIP;
      alu_s   = 3'b000;
      itype_s = 1'b0;
      movf_s  = 1'b0;
      if (op_nop_s) begin
         cls_s = C_SKIP;
      end else begin
         case (op_lo_s)
            4'h0:                   cls_s = C_JMP;
            4'h1, 4'h2, 4'h3, 4'h4: cls_s = C_CJMP;
            4'h5: begin cls_s = C_WB;   alu_s = 3'b000; end
            4'h6: begin cls_s = C_WB;   alu_s = 3'b011; end
            4'h7:                   cls_s = C_STR;
            4'h8:                   cls_s = C_LD;
            4'h9: begin cls_s = C_WB;   alu_s = 3'b110; end
            4'hA: begin cls_s = C_WB;   movf_s = 1'b1; end
            4'hB:                   cls_s = C_HALT;
            4'hC: begin cls_s = C_SKIP; alu_s = 3'b111; end
            4'hD: begin cls_s = C_WB;   alu_s = 3'b001; itype_s = 1'b1; end
            4'hE: begin cls_s = C_WB;   itype_s = 1'b1; end
            4'hF: begin cls_s = C_WB;   alu_s = 3'b101; itype_s = 1'b1; end
            default:                cls_s = C_SKIP;
         endcase
      end
   end

   // Next-state, memory wait counter and per-state datapath controls
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      ir_load   = 1'b0;
      pc_en     = 1'b0;
      pc_branch = 1'b0;
      alu_op    = {ALUW{1'b0}};
      itype     = 1'b0;
      movf      = 1'b0;
      rd_mem    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
            else       state_d = S_IDLE;
         end
         S_FETCH: begin
            ir_load = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            alu_op = ALUW'(alu_s);
            itype  = itype_s;
            movf   = movf_s;
            case (cls_s)
               C_JMP: begin
                  pc_en = 1'b1; pc_branch = 1'b1; retire = 1'b1; state_d = S_FETCH;
               end
               C_CJMP: begin
                  pc_en = 1'b1; pc_branch = cond_true; retire = 1'b1; state_d = S_FETCH;
               end
               C_STR, C_LD: begin
                  wait_d  = {WW{1'b0}};
                  state_d = S_MEM;
               end
               C_WB:   state_d = S_WB;
               C_HALT: begin
                  retire = 1'b1; state_d = S_HALT;
               end
               default: begin
                  pc_en = 1'b1; retire = 1'b1; state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls_s == C_STR);
            // A ready on the limit cycle still completes the access
            if (mem_ready) begin
               wait_d = {WW{1'b0}};
               if (cls_s == C_STR) begin
                  pc_en = 1'b1; retire = 1'b1; state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_q == WAIT_LIMIT) begin
               wait_d    = {WW{1'b0}};
               mem_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            rd_mem    = (cls_s == C_LD);
            pc_en     = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) state_d = S_FETCH;
            else       state_d = S_HALT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
   assign mem_err = mem_err_q;

   // State, opcode, wait counter and sticky error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= {OPW{1'b0}};
         wait_q    <= {WW{1'b0}};
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
         if (state_q == S_FETCH) op_q <= instr;
      end
   end

`ifdef CTRL_RETIRE_CNT_EN
   logic [CNTW-1:0] retire_cnt_q;

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       retire_cnt_q <= {CNTW{1'b0}};
      else if (retire) retire_cnt_q <= retire_cnt_q + CNTW'(1);
   end

   assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are queued with
// their stimulus and compared as the sequencer steps. Retire counter checked with CTRL_RETIRE_CNT_EN.
module tb_multicycle_control;

   localparam int TB_CNTW = 2;

   typedef struct packed {
      logic       ir_load;
      logic       pc_en;
      logic       pc_branch;
      logic [2:0] alu_op;
      logic       itype;
      logic       movf;
      logic       rd_mem;
      logic       mem_req;
      logic       mem_we;
      logic       reg_write;
      logic       busy;
      logic       halted;
      logic       mem_err;
      logic       retire;
   } outs_t;

   typedef struct packed {
      logic       st;
      logic [3:0] ins;
      logic       cnd;
      logic       rdy;
      outs_t      exp;
   } item_t;

   logic clk, reset, start, cond_true, mem_ready;
   logic [3:0] instr;
   logic ir_load, pc_en, pc_branch, itype, movf, rd_mem, mem_req, mem_we;
   logic reg_write, busy, halted, mem_err, retire;
   logic [2:0] alu_op;
`ifdef CTRL_RETIRE_CNT_EN
   logic [TB_CNTW-1:0] retire_count;
`endif

   item_t sb_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    step_n   = 0;
   int    cnt_exp  = 0;
   logic  err_exp  = 1'b0;
   outs_t got_s;

   multicycle_control #(.OPW(4), .ALUW(3), .MEM_TIMEOUT(15), .CNTW(TB_CNTW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .instr     (instr),
      .cond_true (cond_true),
      .mem_ready (mem_ready),
      .ir_load   (ir_load),
      .pc_en     (pc_en),
      .pc_branch (pc_branch),
      .alu_op    (alu_op),
      .itype     (itype),
      .movf      (movf),
      .rd_mem    (rd_mem),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .reg_write (reg_write),
      .busy      (busy),
      .halted    (halted),
      .mem_err   (mem_err),
      .retire    (retire)
`ifdef CTRL_RETIRE_CNT_EN
      ,
      .retire_count (retire_count)
`endif
   );

   assign got_s = '{ir_load, pc_en, pc_branch, alu_op, itype, movf, rd_mem,
                    mem_req, mem_we, reg_write, busy, halted, mem_err, retire};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic outs_t base();
      outs_t o;
      o = '0;
      o.mem_err = err_exp;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rn();
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic push(input logic s, input logic [3:0] i, input logic c, input logic r, input outs_t o);
      item_t it;
      it.st = s; it.ins = i; it.cnd = c; it.rdy = r; it.exp = o;
      sb_q.push_back(it);
   endtask

   task automatic q_idle(input logic in_halt, input int n);
      outs_t o;
      for (int k = 0; k < n; k++) begin
         o = base(); o.halted = in_halt;
         push(1'b0, rn(), rb(), rb(), o);
      end
   endtask

   task automatic q_start(input logic in_halt);
      outs_t o;
      o = base(); o.halted = in_halt;
      push(1'b1, rn(), rb(), rb(), o);
   endtask

   // FETCH, DECODE and EXEC cycles; start is randomised while busy and must be ignored
   task automatic q_head(input logic [3:0] op, input logic cond);
      outs_t o;
      o = base(); o.busy = 1'b1; o.ir_load = 1'b1;
      push(rb(), op, rb(), rb(), o);
      o = base(); o.busy = 1'b1;
      push(rb(), rn(), rb(), rb(), o);
      o = base(); o.busy = 1'b1;
      case (op)
         4'h5: o.alu_op = 3'b000;
         4'h6: o.alu_op = 3'b011;
         4'h9: o.alu_op = 3'b110;
         4'hA: o.movf = 1'b1;
         4'hC: o.alu_op = 3'b111;
         4'hD: begin o.alu_op = 3'b001; o.itype = 1'b1; end
         4'hE: o.itype = 1'b1;
         4'hF: begin o.alu_op = 3'b101; o.itype = 1'b1; end
         default: o.alu_op = 3'b000;
      endcase
      if (op == 4'h0) begin
         o.pc_en = 1'b1; o.pc_branch = 1'b1; o.retire = 1'b1;
      end else if (op >= 4'h1 && op <= 4'h4) begin
         o.pc_en = 1'b1; o.pc_branch = cond; o.retire = 1'b1;
      end else if (op == 4'hC || op == 4'hB) begin
         o.pc_en = (op == 4'hC); o.retire = 1'b1;
      end
      push(rb(), rn(), cond, rb(), o);
   endtask

   task automatic q_mem_wait(input logic [3:0] op, input int n);
      outs_t o;
      for (int k = 0; k < n; k++) begin
         o = base(); o.busy = 1'b1; o.mem_req = 1'b1; o.mem_we = (op == 4'h7);
         push(rb(), rn(), rb(), 1'b0, o);
      end
   endtask

   // Full instruction; mem_cycles counts MEM cycles, mem_ok=0 means the last one times out
   task automatic q_instr(input logic [3:0] op, input logic cond, input int mem_cycles, input logic mem_ok);
      outs_t o;
      q_head(op, cond);
      if (op == 4'h7 || op == 4'h8) begin
         q_mem_wait(op, mem_cycles - 1);
         o = base(); o.busy = 1'b1; o.mem_req = 1'b1; o.mem_we = (op == 4'h7);
         if (mem_ok && op == 4'h7) begin
            o.pc_en = 1'b1; o.retire = 1'b1;
         end
         push(rb(), rn(), rb(), mem_ok, o);
         if (!mem_ok) err_exp = 1'b1;
      end
      if ((op == 4'h8 && mem_ok) || op == 4'h5 || op == 4'h6 || op == 4'h9 || op == 4'hA ||
          op == 4'hD || op == 4'hE || op == 4'hF) begin
         o = base(); o.busy = 1'b1; o.reg_write = 1'b1; o.rd_mem = (op == 4'h8);
         o.pc_en = 1'b1; o.retire = 1'b1;
         push(rb(), rn(), rb(), rb(), o);
      end
   endtask

   task automatic drain();
      item_t it;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         start = it.st; instr = it.ins; cond_true = it.cnd; mem_ready = it.rdy;
         @(negedge clk);
         chk($sformatf("step%0d", step_n), 32'(got_s), 32'(it.exp));
`ifdef CTRL_RETIRE_CNT_EN
         chk($sformatf("cnt%0d", step_n), 32'(retire_count), 32'(cnt_exp));
         if (it.exp.retire) cnt_exp = (cnt_exp + 1) % (1 << TB_CNTW);
`endif
         step_n++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; instr = 4'h0; cond_true = 1'b0; mem_ready = 1'b0;
      #12;
      chk("reset_outs", 32'(got_s), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      q_idle(1'b0, 2);
      q_start(1'b0);
      q_instr(4'h5, 1'b0, 0, 1'b1);
      q_instr(4'h6, 1'b0, 0, 1'b1);
      q_instr(4'h9, 1'b1, 0, 1'b1);
      q_instr(4'hC, 1'b0, 0, 1'b1);
      q_instr(4'hD, 1'b0, 0, 1'b1);
      q_instr(4'hE, 1'b0, 0, 1'b1);
      q_instr(4'hF, 1'b0, 0, 1'b1);
      q_instr(4'hA, 1'b0, 0, 1'b1);
      q_instr(4'h0, 1'b0, 0, 1'b1);
      q_instr(4'h2, 1'b0, 0, 1'b1);
      q_instr(4'h2, 1'b1, 0, 1'b1);
      q_instr(4'h1, 1'b1, 0, 1'b1);
      q_instr(4'h4, 1'b0, 0, 1'b1);
      q_instr(4'h3, 1'b1, 0, 1'b1);
      q_instr(4'h8, 1'b0, 3, 1'b1);
      q_instr(4'h7, 1'b0, 1, 1'b1);
      q_instr(4'h8, 1'b0, 1, 1'b1);
      q_instr(4'h7, 1'b0, 15, 1'b1);
      q_instr(4'h8, 1'b0, 15, 1'b1);
      q_instr(4'hB, 1'b0, 0, 1'b1);
      q_idle(1'b1, 2);
      q_start(1'b1);
      q_instr(4'h7, 1'b0, 15, 1'b0);
      q_idle(1'b1, 2);
      q_start(1'b1);
      q_instr(4'h5, 1'b0, 0, 1'b1);
      q_instr(4'hB, 1'b0, 0, 1'b1);
      q_idle(1'b1, 1);
      q_start(1'b1);
      q_head(4'h8, 1'b0);
      q_mem_wait(4'h8, 2);
      drain();

      // Asynchronous reset in the third MEM cycle of a load
      start = 1'b0; mem_ready = 1'b0;
      chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_reset_outs", 32'(got_s), 32'd0);
      err_exp = 1'b0;
      cnt_exp = 0;
`ifdef CTRL_RETIRE_CNT_EN
      chk("async_reset_cnt", 32'(retire_count), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      q_idle(1'b0, 1);
      q_start(1'b0);
      q_instr(4'h5, 1'b0, 0, 1'b1);
      q_instr(4'hB, 1'b0, 0, 1'b1);
      q_idle(1'b1, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
